pe_aes_vec: RTL and testbench

Parametrised successor to the 8-bit AES processing element in the 2D systolic array. It carries LANES independent byte lanes per PE, and supports LOAD, AddRoundKey XOR, SHIFT and a multi-beat GF(2^8) MixColumns accumulate. The accumulate works in both forward and inverse mode, and the PE's row position selects the coefficient rotation. The block sits at each array node next to the FeRAM near-memory interface and forwards data south and east every enabled cycle.

---
 rtl/aes_pe_pkg.sv | 33 +++
 rtl/gf_mul8.sv | 28 ++
 rtl/pe_aes_vec.sv | 123 ++++++++++++
 tb/tb_pe_aes_vec.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pe_pkg.sv
// Shared definitions for the vector AES processing element: op codes,
// MixColumns coefficient tables, FSM state type and GF(2^8) helpers.
package aes_pe_pkg;

    // Operation codes carried on op_sel; codes 101-111 fall through as HOLD
    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_ADDKEY = 3'b010;
    localparam logic [2:0] OP_MIXCOL = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;

    // MixColumns coefficient rows, element [0] is the leading coefficient
    // (forward 02,03,01,01 and inverse 0E,0B,0D,09)
    localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0D, 8'h0B, 8'h0E};

    // Two-state controller: IDLE accepts ops, ACC runs the MixColumns beats
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pe_state_t;

    // Multiply by x in GF(2^8) with reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Pick the coefficient for a rotated index in forward or inverse mode
    function automatic logic [7:0] coef_sel(input logic [1:0] idx, input logic inv_mode);
        return inv_mode ? INV_COEF[idx] : FWD_COEF[idx];
    endfunction

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiply of one data byte by a coefficient byte.
// The data byte is walked through an xtime chain and the powers selected by
// the coefficient bits are XOR-summed.
module gf_mul8
    import aes_pe_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] coef,
    output logic [7:0] prod
);

    logic [7:0] pow [8];

    // Build a*x^i for every i, then accumulate the terms selected by coef
    always_comb begin
        pow[0] = a;
        for (int i = 1; i < 8; i++) begin
            pow[i] = xtime(pow[i-1]);
        end
        prod = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (coef[i]) begin
                prod = prod ^ pow[i];
            end
        end
    end

endmodule

// File: rtl/pe_aes_vec.sv
// Vector AES processing element for one systolic array node. Each of the
// LANES byte lanes is independent; all lanes share one controller, so a
// MixColumns accumulate runs on every lane at once. data_w is forwarded east
// and the psum register south on every enabled cycle.
module pe_aes_vec
    import aes_pe_pkg::*;
#(
    parameter int LANES = 1,
    parameter int ROW   = 0,
    parameter int COL   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pe_en,
    input  logic [2:0]           op_sel,
    input  logic                 inv,
    input  logic [8*LANES-1:0]   data_n,
    input  logic [8*LANES-1:0]   data_w,
    input  logic [8*LANES-1:0]   key,
    output logic [8*LANES-1:0]   data_s,
    output logic [8*LANES-1:0]   data_e,
    output logic                 mc_busy,
    output logic                 mc_done
);

    localparam int         W       = 8 * LANES;
    localparam logic [1:0] ROW_IDX = 2'(ROW);

    // COL only identifies the node; ROW must address one of the four rows
    if (COL < 0 || ROW < 0 || ROW > 3) begin : g_param_guard
    end

    pe_state_t  state;
    logic [1:0] beat;
    logic       inv_q;
    logic       busy_q;
    logic       done_q;
    logic [W-1:0] psum;
    logic [W-1:0] acc;
    logic [W-1:0] data_e_q;
    logic [W-1:0] prod;
    logic [W-1:0] acc_next;
    logic [1:0] coef_idx;
    logic       coef_inv;
    logic [7:0] coef;

    // Coefficient for the current beat, rotated by the row position. In IDLE
    // the beat counter is zero and the live inv input chooses the mode, since
    // that edge is the one that starts the accumulate.
    always_comb begin
        coef_inv = (state == ST_ACC) ? inv_q : inv;
        coef_idx = beat - ROW_IDX;
        coef     = coef_sel(coef_idx, coef_inv);
    end

    // One multiplier per lane, all sharing the same coefficient
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf_mul8 u_mul (
            .a    (data_w[8*i +: 8]),
            .coef (coef),
            .prod (prod[8*i +: 8])
        );
    end

    assign acc_next = acc ^ prod;

    // Controller, beat counter and all datapath registers. mc_done is a
    // single-cycle pulse, so it clears on every edge regardless of pe_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat     <= 2'd0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            psum     <= '0;
            acc      <= '0;
            data_e_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (pe_en) begin
                data_e_q <= data_w;
                case (state)
                    ST_IDLE: begin
                        case (op_sel)
                            OP_HOLD:   ;
                            OP_LOAD:   psum <= data_n;
                            OP_ADDKEY: psum <= psum ^ key;
                            OP_SHIFT:  psum <= data_w;
                            OP_MIXCOL: begin
                                acc    <= prod;
                                inv_q  <= inv;
                                beat   <= 2'd1;
                                busy_q <= 1'b1;
                                state  <= ST_ACC;
                            end
                            default:   ;
                        endcase
                    end
                    ST_ACC: begin
                        acc <= acc_next;
                        if (beat == 2'd3) begin
                            psum   <= acc_next;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            beat   <= 2'd0;
                            state  <= ST_IDLE;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_s  = psum;
    assign data_e  = data_e_q;
    assign mc_busy = busy_q;
    assign mc_done = done_q;

endmodule

// File: tb/tb_pe_aes_vec.sv
// Scoreboard bench for pe_aes_vec: a 4-lane row-0 node and a 1-lane row-1
// node share stimulus. A behavioural model predicts every edge; MixColumns
// results are queued and popped by a monitor whenever mc_done is seen.
module tb_pe_aes_vec;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_ADDKEY = 3'd2;
    localparam logic [2:0] OP_MIXCOL = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe_en = 1'b0;
    logic        inv = 1'b0;
    logic [2:0]  op_sel = 3'd0;
    logic [31:0] data_n = '0;
    logic [31:0] data_w = '0;
    logic [31:0] key = '0;

    logic [31:0] data_s0, data_e0;
    logic        busy0, done0;
    logic [7:0]  data_s1, data_e1;
    logic        busy1, done1;

    int check_count = 0;
    int err_count = 0;
    bit mon_on = 1'b0;

    logic [31:0] m_psum0 = '0;
    logic [7:0]  m_psum1 = '0;
    logic [31:0] m_e0 = '0;
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    bit          m_inv = 1'b0;
    logic [31:0] m_beats[$];
    logic [31:0] sb0[$];
    logic [7:0]  sb1[$];

    always #5 clk = ~clk;

    pe_aes_vec #(.LANES(4), .ROW(0), .COL(0)) dut0 (
        .clk(clk), .rst(rst), .pe_en(pe_en), .op_sel(op_sel), .inv(inv),
        .data_n(data_n), .data_w(data_w), .key(key),
        .data_s(data_s0), .data_e(data_e0), .mc_busy(busy0), .mc_done(done0)
    );

    pe_aes_vec #(.LANES(1), .ROW(1), .COL(1)) dut1 (
        .clk(clk), .rst(rst), .pe_en(pe_en), .op_sel(op_sel), .inv(inv),
        .data_n(data_n[7:0]), .data_w(data_w[7:0]), .key(key[7:0]),
        .data_s(data_s1), .data_e(data_e1), .mc_busy(busy1), .mc_done(done1)
    );

    // Schoolbook carry-less product followed by polynomial reduction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int k = 15; k >= 8; k--) begin
            if (p[k]) p = p ^ (16'h011B << (k - 8));
        end
        return p[7:0];
    endfunction

    // One output byte of (Inv)MixColumns for the given row of a column
    function automatic logic [7:0] mix_lane(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input int row, input bit inv_mode);
        logic [7:0] col [4];
        logic [7:0] cf [4];
        logic [7:0] res;
        col = '{b0, b1, b2, b3};
        if (inv_mode) cf = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else          cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = 8'h00;
        for (int j = 0; j < 4; j++) begin
            res = res ^ gmul(col[j], cf[(j - row + 4) % 4]);
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge with the given inputs
    task automatic model_edge(input bit en, input logic [2:0] op, input bit iv,
                              input logic [31:0] n, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] bt [4];
        logic [31:0] r0;
        logic [7:0]  r1;
        m_done = 1'b0;
        if (en) begin
            m_e0 = w;
            if (!m_active) begin
                case (op)
                    OP_LOAD:   begin m_psum0 = n; m_psum1 = n[7:0]; end
                    OP_ADDKEY: begin m_psum0 = m_psum0 ^ k; m_psum1 = m_psum1 ^ k[7:0]; end
                    OP_SHIFT:  begin m_psum0 = w; m_psum1 = w[7:0]; end
                    OP_MIXCOL: begin
                        m_active = 1'b1;
                        m_inv = iv;
                        m_beats.delete();
                        m_beats.push_back(w);
                    end
                    default: ;
                endcase
            end else begin
                m_beats.push_back(w);
                if (m_beats.size() == 4) begin
                    for (int j = 0; j < 4; j++) bt[j] = m_beats[j];
                    for (int l = 0; l < 4; l++) begin
                        r0[8*l +: 8] = mix_lane(bt[0][8*l +: 8], bt[1][8*l +: 8],
                                                bt[2][8*l +: 8], bt[3][8*l +: 8], 0, m_inv);
                    end
                    r1 = mix_lane(bt[0][7:0], bt[1][7:0], bt[2][7:0], bt[3][7:0], 1, m_inv);
                    sb0.push_back(r0);
                    sb1.push_back(r1);
                    m_psum0 = r0;
                    m_psum1 = r1;
                    m_done = 1'b1;
                    m_active = 1'b0;
                    m_beats.delete();
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit en, input logic [2:0] op, input bit iv,
                                 input logic [31:0] n, input logic [31:0] w, input logic [31:0] k);
        pe_en = en;
        op_sel = op;
        inv = iv;
        data_n = n;
        data_w = w;
        key = k;
        @(posedge clk);
        model_edge(en, op, iv, n, w, k);
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        m_psum0 = '0;
        m_psum1 = '0;
        m_e0 = '0;
        m_active = 1'b0;
        m_done = 1'b0;
        m_inv = 1'b0;
        m_beats.delete();
        #1;
        checkOutput("async_rst_data_s0", data_s0, 32'h0);
        checkOutput("async_rst_data_e0", data_e0, 32'h0);
        checkOutput("async_rst_busy0", 32'(busy0), 32'h0);
        checkOutput("async_rst_data_s1", 32'(data_s1), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: compare every output against the model, and pop the
    // scoreboard whenever a MixColumns result is presented
    always @(negedge clk) begin
        if (mon_on) begin
            checkOutput("data_s0", data_s0, m_psum0);
            checkOutput("data_e0", data_e0, m_e0);
            checkOutput("mc_busy0", 32'(busy0), 32'(m_active));
            checkOutput("mc_done0", 32'(done0), 32'(m_done));
            checkOutput("data_s1", 32'(data_s1), 32'(m_psum1));
            checkOutput("data_e1", 32'(data_e1), 32'(m_e0[7:0]));
            checkOutput("mc_busy1", 32'(busy1), 32'(m_active));
            checkOutput("mc_done1", 32'(done1), 32'(m_done));
            if (done0) begin
                if (sb0.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL mc_result0: got %h expected no result", data_s0);
                end else begin
                    checkOutput("mc_result0", data_s0, sb0.pop_front());
                end
            end
            if (done1) begin
                if (sb1.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL mc_result1: got %h expected no result", data_s1);
                end else begin
                    checkOutput("mc_result1", 32'(data_s1), 32'(sb1.pop_front()));
                end
            end
        end
    end

    initial begin
        int busy_cycles;
        int latency;
        int edge_no;

        repeat (2) @(negedge clk);
        checkOutput("reset_data_s0", data_s0, 32'h0);
        checkOutput("reset_data_e0", data_e0, 32'h0);
        checkOutput("reset_busy0", 32'(busy0), 32'h0);
        checkOutput("reset_done0", 32'(done0), 32'h0);
        checkOutput("reset_data_s1", 32'(data_s1), 32'h0);
        #2 rst = 1'b0;
        mon_on = 1'b1;

        // LOAD then ADDKEY
        applyStimulus(1, OP_LOAD, 0, 32'hABABABAB, 32'h11223344, 32'h0);
        checkOutput("load_s0", data_s0, 32'hABABABAB);
        checkOutput("load_s1", 32'(data_s1), 32'hAB);
        applyStimulus(1, OP_ADDKEY, 0, 32'h0, 32'h55667788, 32'h12121212);
        checkOutput("addkey_s0", data_s0, 32'hB9B9B9B9);
        checkOutput("addkey_s1", 32'(data_s1), 32'hB9);

        // Forward MixColumns on four columns, LOAD requests ignored in ACC
        applyStimulus(1, OP_MIXCOL, 0, 32'h0, 32'h1EB8E0D4, 32'h0);
        applyStimulus(1, OP_LOAD, 0, 32'hFFFFFFFF, 32'h2741B4BF, 32'h0);
        checkOutput("no_partial_s0", data_s0, 32'hB9B9B9B9);
        applyStimulus(1, OP_LOAD, 1, 32'hFFFFFFFF, 32'h9811525D, 32'h0);
        applyStimulus(1, OP_LOAD, 0, 32'hFFFFFFFF, 32'hE5F1AE30, 32'h0);
        checkOutput("fwd_done0", 32'(done0), 32'h1);
        checkOutput("fwd_s0", data_s0, 32'h2848E004);
        checkOutput("fwd_row1_s1", 32'(data_s1), 32'h66);

        // Inverse MixColumns, counting busy cycles
        busy_cycles = 0;
        applyStimulus(1, OP_MIXCOL, 1, 32'h0, 32'h04040404, 32'h0);
        if (busy0) busy_cycles++;
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h66666666, 32'h0);
        if (busy0) busy_cycles++;
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h81818181, 32'h0);
        if (busy0) busy_cycles++;
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'hE5E5E5E5, 32'h0);
        if (busy0) busy_cycles++;
        checkOutput("inv_s0", data_s0, 32'hD4D4D4D4);
        checkOutput("inv_row1_s1", 32'(data_s1), 32'hBF);
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h0, 32'h0);
        if (busy0) busy_cycles++;
        checkOutput("inv_busy_cycles", 32'(busy_cycles), 32'd3);

        // Forward MixColumns with a two-cycle stall after beat 1
        latency = 0;
        edge_no = 0;
        for (int s = 0; s < 8 && latency == 0; s++) begin
            edge_no++;
            case (s)
                0: applyStimulus(1, OP_MIXCOL, 0, 32'h0, 32'h1EB8E0D4, 32'h0);
                1: applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h2741B4BF, 32'h0);
                2: begin
                    applyStimulus(0, OP_HOLD, 0, 32'h0, $urandom, 32'h0);
                    checkOutput("stall_data_e0", data_e0, 32'h2741B4BF);
                end
                3: applyStimulus(0, OP_LOAD, 0, 32'h0, $urandom, 32'h0);
                4: applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h9811525D, 32'h0);
                default: applyStimulus(1, OP_HOLD, 0, 32'h0, 32'hE5F1AE30, 32'h0);
            endcase
            if (done0) latency = edge_no;
        end
        checkOutput("stall_latency", 32'(latency), 32'd6);
        checkOutput("stall_s0", data_s0, 32'h2848E004);

        // Reset in the middle of an accumulate
        applyStimulus(1, OP_MIXCOL, 0, 32'h0, 32'h1EB8E0D4, 32'h0);
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h2741B4BF, 32'h0);
        doReset();
        applyStimulus(1, OP_HOLD, 0, 32'h0, 32'h9811525D, 32'h0);
        checkOutput("post_rst_done0", 32'(done0), 32'h0);
        checkOutput("post_rst_s0", data_s0, 32'h0);

        // Randomised traffic, biased towards MixColumns
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 59) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 9) != 0,
                              ($urandom_range(0, 3) == 0) ? OP_MIXCOL : 3'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
            end
        end

        // Drain any accumulate still in flight
        repeat (6) applyStimulus(1, OP_HOLD, 0, 32'h0, $urandom, 32'h0);
        checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
        checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
        $finish;
    end

endmodule
